// File: rtl/tour_cmd.sv
// Replays a solved knight's tour as cmd_proc commands: each one-hot move becomes a
// vertical leg followed by a horizontal leg with fanfare. UART commands pass through when idle.
module tour_cmd #(
    parameter int NUM_MOVES = 24
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_tour,
    input  logic [7:0]  move,
    output logic [4:0]  mv_indx,
    input  logic [15:0] cmd_UART,
    input  logic        cmd_rdy_UART,
    input  logic        clr_cmd_rdy,
    input  logic        send_resp,
    output logic [15:0] cmd,
    output logic        cmd_rdy,
    output logic        clr_cmd_rdy_UART,
    output logic [7:0]  resp
);
    typedef enum logic [2:0] {IDLE, VERT, WAIT_V, HORZ, WAIT_H} state_t;

    localparam logic [4:0] LAST = 5'(NUM_MOVES - 1);

    state_t      state, nxt_state;
    logic [4:0]  nxt_indx;
    logic [2:0]  sel;
    logic [15:0] vert_cmd, horz_cmd;

    // Lowest set bit wins; an empty move falls back to bit 0.
    always_comb begin
        sel = 3'd0;
        for (int i = 7; i >= 0; i--)
            if (move[i]) sel = 3'(i);
    end

    always_comb begin
        case (sel)
            3'd0:    begin vert_cmd = 16'h4002; horz_cmd = 16'h5BF1; end
            3'd1:    begin vert_cmd = 16'h4002; horz_cmd = 16'h53F1; end
            3'd2:    begin vert_cmd = 16'h4001; horz_cmd = 16'h53F2; end
            3'd3:    begin vert_cmd = 16'h47F1; horz_cmd = 16'h53F2; end
            3'd4:    begin vert_cmd = 16'h47F2; horz_cmd = 16'h53F1; end
            3'd5:    begin vert_cmd = 16'h47F2; horz_cmd = 16'h5BF1; end
            3'd6:    begin vert_cmd = 16'h47F1; horz_cmd = 16'h5BF2; end
            default: begin vert_cmd = 16'h4001; horz_cmd = 16'h5BF2; end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            mv_indx <= 5'd0;
        end else begin
            state   <= nxt_state;
            mv_indx <= nxt_indx;
        end
    end

    always_comb begin
        nxt_state = state;
        nxt_indx  = mv_indx;
        case (state)
            IDLE:   if (start_tour) begin
                        nxt_state = VERT;
                        nxt_indx  = 5'd0;
                    end
            VERT:   if (clr_cmd_rdy) nxt_state = WAIT_V;
            WAIT_V: if (send_resp)   nxt_state = HORZ;
            HORZ:   if (clr_cmd_rdy) nxt_state = WAIT_H;
            WAIT_H: if (send_resp) begin
                        if (mv_indx == LAST) begin
                            nxt_state = IDLE;
                        end else begin
                            nxt_state = VERT;
                            nxt_indx  = mv_indx + 5'd1;
                        end
                    end
            default: nxt_state = IDLE;
        endcase
    end

    // Output mux: UART passthrough in IDLE, tour commands otherwise.
    always_comb begin
        cmd              = cmd_UART;
        cmd_rdy          = cmd_rdy_UART;
        clr_cmd_rdy_UART = clr_cmd_rdy;
        resp             = 8'hA5;
        if (state != IDLE) begin
            cmd              = (state == HORZ || state == WAIT_H) ? horz_cmd : vert_cmd;
            cmd_rdy          = (state == VERT || state == HORZ);
            clr_cmd_rdy_UART = 1'b0;
            resp             = (state == WAIT_H && mv_indx == LAST) ? 8'hA5 : 8'h5A;
        end
    end
endmodule

// File: tb/tb_tour_cmd.sv
// Directed bench for tour_cmd: UART passthrough, single move, full tour,
// handshake corner cases, and reset mid-tour.
module tb_tour_cmd;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_tour;
    logic [7:0]  move;
    logic [4:0]  mv_indx;
    logic [15:0] cmd_UART;
    logic        cmd_rdy_UART;
    logic        clr_cmd_rdy;
    logic        send_resp;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy_UART;
    logic [7:0]  resp;

    int n_cmp = 0;
    int n_err = 0;
    int n_cmds = 0;

    logic [7:0]  mem  [24];
    int          ebit [24];
    logic [15:0] vexp [8] = '{16'h4002, 16'h4002, 16'h4001, 16'h47F1, 16'h47F2, 16'h47F2, 16'h47F1, 16'h4001};
    logic [15:0] hexp [8] = '{16'h5BF1, 16'h53F1, 16'h53F2, 16'h53F2, 16'h53F1, 16'h5BF1, 16'h5BF2, 16'h5BF2};

    always #5 clk = ~clk;

    // Move memory model: combinational read at mv_indx.
    assign move = (mv_indx < 5'd24) ? mem[mv_indx] : 8'h00;

    tour_cmd #(.NUM_MOVES(24)) dut (
        .clk(clk), .rst_n(rst_n), .start_tour(start_tour), .move(move), .mv_indx(mv_indx),
        .cmd_UART(cmd_UART), .cmd_rdy_UART(cmd_rdy_UART), .clr_cmd_rdy(clr_cmd_rdy),
        .send_resp(send_resp), .cmd(cmd), .cmd_rdy(cmd_rdy),
        .clr_cmd_rdy_UART(clr_cmd_rdy_UART), .resp(resp)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Pulse one input for a single clock.
    task automatic pulse_clr();  clr_cmd_rdy = 1'b1; step(); clr_cmd_rdy = 1'b0; endtask
    task automatic pulse_resp(); send_resp   = 1'b1; step(); send_resp   = 1'b0; endtask

    initial begin
        for (int i = 0; i < 24; i++) begin
            mem[i]  = 8'(1 << (i % 8));
            ebit[i] = i % 8;
        end
        mem[10] = 8'b0110_0000; ebit[10] = 5;   // non-one-hot: bit5 lowest
        mem[11] = 8'h00;        ebit[11] = 0;   // empty move decodes as bit0

        rst_n = 1'b0; start_tour = 1'b0; cmd_UART = 16'h1234; cmd_rdy_UART = 1'b0;
        clr_cmd_rdy = 1'b0; send_resp = 1'b0;
        step(); step();
        chk("rst_cmd", cmd, 16'h1234);
        chk("rst_cmd_rdy", 16'(cmd_rdy), 16'h0);
        chk("rst_resp", 16'(resp), 16'h00A5);
        chk("rst_mv_indx", 16'(mv_indx), 16'h0);
        rst_n = 1'b1;
        step();

        // IDLE passthrough
        cmd_UART = 16'h2000; cmd_rdy_UART = 1'b1; clr_cmd_rdy = 1'b1; #1;
        chk("pt_cmd", cmd, 16'h2000);
        chk("pt_cmd_rdy", 16'(cmd_rdy), 16'h1);
        chk("pt_clr", 16'(clr_cmd_rdy_UART), 16'h1);
        chk("pt_resp", 16'(resp), 16'h00A5);
        step(); clr_cmd_rdy = 1'b0;

        // Single move at index 0; UART request stays pending throughout
        start_tour = 1'b1; step(); start_tour = 1'b0;
        chk("m0_vcmd", cmd, 16'h4002);
        chk("m0_vrdy", 16'(cmd_rdy), 16'h1);
        chk("m0_resp", 16'(resp), 16'h005A);
        chk("m0_uclr", 16'(clr_cmd_rdy_UART), 16'h0);
        pulse_resp();                                   // send_resp before clr: ignored
        chk("vert_early_resp_cmd", cmd, 16'h4002);
        chk("vert_early_resp_rdy", 16'(cmd_rdy), 16'h1);
        clr_cmd_rdy = 1'b1; #1;
        chk("tour_clr_uart", 16'(clr_cmd_rdy_UART), 16'h0);
        step(); clr_cmd_rdy = 1'b0;
        chk("m0_waitv_rdy", 16'(cmd_rdy), 16'h0);
        pulse_clr();                                    // clr in WAIT_V: ignored
        chk("waitv_clr_rdy", 16'(cmd_rdy), 16'h0);
        pulse_resp();
        chk("m0_hcmd", cmd, 16'h5BF1);
        chk("m0_hrdy", 16'(cmd_rdy), 16'h1);
        pulse_clr();
        chk("m0_waith_resp", 16'(resp), 16'h005A);
        pulse_resp();
        chk("m0_next_indx", 16'(mv_indx), 16'h1);
        chk("m0_next_resp", 16'(resp), 16'h005A);
        n_cmds += 2;

        // Index 1: clr+send_resp together in HORZ
        chk("m1_vcmd", cmd, 16'h4002);
        pulse_clr(); pulse_resp();
        chk("m1_hcmd", cmd, 16'h53F1);
        clr_cmd_rdy = 1'b1; send_resp = 1'b1; step(); clr_cmd_rdy = 1'b0; send_resp = 1'b0;
        chk("both_rdy", 16'(cmd_rdy), 16'h0);
        step();
        chk("both_hold_indx", 16'(mv_indx), 16'h1);
        start_tour = 1'b1; step(); start_tour = 1'b0;   // start_tour mid-tour: ignored
        chk("start_mid_indx", 16'(mv_indx), 16'h1);
        pulse_resp();
        chk("m1_adv_indx", 16'(mv_indx), 16'h2);
        n_cmds += 2;

        // Remainder of the tour
        for (int i = 2; i < 24; i++) begin
            chk($sformatf("t%0d_indx", i), 16'(mv_indx), 16'(i));
            chk($sformatf("t%0d_vcmd", i), cmd, vexp[ebit[i]]);
            chk($sformatf("t%0d_vrdy", i), 16'(cmd_rdy), 16'h1);
            if (cmd === cmd_UART) chk($sformatf("t%0d_not_uart", i), cmd, ~cmd_UART);
            pulse_clr();
            chk($sformatf("t%0d_wrdy", i), 16'(cmd_rdy), 16'h0);
            pulse_resp();
            chk($sformatf("t%0d_hcmd", i), cmd, hexp[ebit[i]]);
            chk($sformatf("t%0d_hrdy", i), 16'(cmd_rdy), 16'h1);
            pulse_clr();
            chk($sformatf("t%0d_waith_resp", i), 16'(resp), (i == 23) ? 16'h00A5 : 16'h005A);
            n_cmds += 2;
            pulse_resp();
        end
        chk("tour_cmds", 16'(n_cmds), 16'd48);
        chk("done_indx", 16'(mv_indx), 16'd23);
        chk("done_cmd_uart", cmd, 16'h2000);
        chk("done_rdy_uart", 16'(cmd_rdy), 16'h1);
        chk("done_resp", 16'(resp), 16'h00A5);
        step();
        chk("done_stays_idle", 16'(mv_indx), 16'd23);

        // Restart, run to WAIT_H at index 7, then reset
        start_tour = 1'b1; step(); start_tour = 1'b0;
        chk("restart_indx", 16'(mv_indx), 16'h0);
        for (int i = 0; i < 7; i++) begin
            pulse_clr(); pulse_resp(); pulse_clr(); pulse_resp();
        end
        chk("r7_indx", 16'(mv_indx), 16'd7);
        pulse_clr(); pulse_resp(); pulse_clr();
        chk("r7_waith_rdy", 16'(cmd_rdy), 16'h0);
        @(negedge clk); rst_n = 1'b0; #1;
        chk("arst_indx", 16'(mv_indx), 16'h0);
        chk("arst_rdy", 16'(cmd_rdy), 16'h1);
        chk("arst_cmd", cmd, 16'h2000);
        chk("arst_resp", 16'(resp), 16'h00A5);
        step(); rst_n = 1'b1; step();
        chk("post_rst_idle_rdy", 16'(cmd_rdy), 16'h1);
        start_tour = 1'b1; step(); start_tour = 1'b0;
        chk("rerun_indx", 16'(mv_indx), 16'h0);
        chk("rerun_vcmd", cmd, 16'h4002);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
